// File: rtl/cordic_atan2.sv
// Iterative CORDIC vectoring engine: (x, y) -> {quadrant, angle, magnitude}.
// The input is folded into quadrant 0, then N micro-rotations drive y toward
// zero while z accumulates the rotated angle. A final step scales the
// magnitude by the reciprocal CORDIC gain and clamps the angle.
module cordic_atan2 #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int AW = 16,
  parameter logic [N*AW-1:0] ATAN = {
    16'd1,    16'd3,    16'd5,     16'd10,
    16'd20,   16'd41,   16'd81,    16'd163,
    16'd326,  16'd652,  16'd1303,  16'd2604,
    16'd5188, 16'd10221, 16'd19344, 16'd32768},
  parameter int KW = 16,
  parameter int K  = 39797
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [1:0]    quadrant_o,
  output logic [AW-1:0] angle_o,
  output logic [DW:0]   magnitude_o
);

  // Fractional guard bits below the input LSB keep the residual y small
  // enough that the final angle resolves to within a couple of LSBs.
  localparam int GW = 8;
  localparam int XW = DW + 2 + GW;
  localparam int ZW = AW + 2;
  localparam int CW = $clog2(N + 1);
  localparam int MW = XW + KW;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;

  state_t               r_state;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic [1:0]           r_q;
  logic                 r_zero;
  logic [CW-1:0]        r_cnt;
  logic                 r_ready;
  logic                 r_valid;
  logic [1:0]           r_quad;
  logic [AW-1:0]        r_angle;
  logic [DW:0]          r_mag;

  // Sign-extend inputs by two bits and append the guard bits.
  logic signed [XW-1:0] w_xe;
  logic signed [XW-1:0] w_ye;
  assign w_xe = {{2{x_i[DW-1]}}, x_i, {GW{1'b0}}};
  assign w_ye = {{2{y_i[DW-1]}}, y_i, {GW{1'b0}}};

  logic w_xneg, w_yneg, w_xz, w_yz;
  assign w_xneg = x_i[DW-1];
  assign w_yneg = y_i[DW-1];
  assign w_xz   = (x_i == '0);
  assign w_yz   = (y_i == '0);

  logic [1:0]           w_fq;
  logic signed [XW-1:0] w_fx;
  logic signed [XW-1:0] w_fy;

  // Rotate the input by a multiple of 90 degrees into x>0, y>=0.
  always_comb begin
    w_fq = 2'd0;
    w_fx = w_xe;
    w_fy = w_ye;
    if (w_xz && w_yz) begin
      w_fq = 2'd0;
    end else if (!w_xneg && !w_xz && !w_yneg) begin
      w_fq = 2'd0;
    end else if ((w_xneg || w_xz) && !w_yneg && !w_yz) begin
      w_fq = 2'd1;
      w_fx = w_ye;
      w_fy = -w_xe;
    end else if (w_xneg && (w_yneg || w_yz)) begin
      w_fq = 2'd2;
      w_fx = -w_xe;
      w_fy = -w_ye;
    end else begin
      w_fq = 2'd3;
      w_fx = -w_ye;
      w_fy = w_xe;
    end
  end

  // Per-iteration shifted operands and table entry.
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic [AW-1:0]        w_atan;
  logic signed [ZW-1:0] w_atan_e;
  assign w_xs     = r_x >>> r_cnt;
  assign w_ys     = r_y >>> r_cnt;
  assign w_atan   = ATAN[r_cnt*AW +: AW];
  assign w_atan_e = signed'({2'b00, w_atan});

  // x only grows during vectoring and starts non-negative, so it is scaled
  // as an unsigned quantity; rounding drops both KW and the guard bits.
  logic [MW-1:0] w_prod;
  logic [MW-1:0] w_round;
  logic [MW-1:0] w_shift;
  logic [DW:0]   w_mag;
  assign w_prod  = MW'($unsigned(r_x)) * MW'(K);
  assign w_round = w_prod + (MW'(1) << (KW + GW - 1));
  assign w_shift = w_round >> (KW + GW);
  assign w_mag   = (|w_shift[MW-1:DW+1]) ? {(DW+1){1'b1}} : w_shift[DW:0];

  // Clamp z into one quadrant; a (0,0) input has no defined angle and maps to 0.
  logic [AW-1:0] w_angle;
  always_comb begin
    w_angle = r_z[AW-1:0];
    if (r_zero || r_z[ZW-1]) begin
      w_angle = '0;
    end else if (r_z[ZW-2:AW] != '0) begin
      w_angle = {AW{1'b1}};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_q     <= '0;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_quad  <= '0;
      r_angle <= '0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (valid_i && r_ready) begin
            r_x     <= w_fx;
            r_y     <= w_fy;
            r_z     <= '0;
            r_q     <= w_fq;
            r_zero  <= w_xz && w_yz;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan_e;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan_e;
          end
          if (r_cnt == CW'(N - 1)) begin
            r_state <= S_SCALE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SCALE: begin
          r_quad  <= r_q;
          r_angle <= w_angle;
          r_mag   <= w_mag;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign quadrant_o  = r_quad;
  assign angle_o     = r_angle;
  assign magnitude_o = r_mag;

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2: table of vectors plus stall and
// mid-operation reset sequences.
module tb_cordic_atan2;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] x_i = '0;
  logic [DW-1:0] y_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [1:0]    quadrant_o;
  logic [AW-1:0] angle_o;
  logic [DW:0]   magnitude_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_atan2 dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .quadrant_o  (quadrant_o),
    .angle_o     (angle_o),
    .magnitude_o (magnitude_o)
  );

  typedef struct {
    int x;
    int y;
    int q;
    int a;
    int atol;
    int m;
    int mtol;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic near(input string name, input int act, input int exp, input int tol);
    check(name, (act >= exp - tol) && (act <= exp + tol), act, exp);
  endtask

  // Offer one sample, wait for acceptance, then count edges until valid_o.
  task automatic run_sample(input int x, input int y, output int q, output int a,
                            output int m, output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    lat = 0;
    q = 0; a = 0; m = 0;
    @(negedge clk);
    x_i = 16'(x);
    y_i = 16'(y);
    valid_i = 1'b1;
    w = 0;
    while (!ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) begin
      ok = 1'b0;
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    // Inputs changing after the accept edge must not matter.
    x_i = 16'h8123;
    y_i = 16'h7abc;
    while (!valid_o && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!valid_o) ok = 1'b0;
    q = int'(quadrant_o);
    a = int'(angle_o);
    m = int'(magnitude_o);
  endtask

  task automatic release_result();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, a, m, lat, seen;
    bit ok;

    vecs[0] = '{x: 1000,   y: 0,      q: 0, a: 0,     atol: 2, m: 1000,  mtol: 2};
    vecs[1] = '{x: 0,      y: 1000,   q: 1, a: 0,     atol: 2, m: 1000,  mtol: 2};
    vecs[2] = '{x: -1000,  y: -1,     q: 2, a: 42,    atol: 2, m: 1000,  mtol: 2};
    vecs[3] = '{x: 0,      y: 0,      q: 0, a: 0,     atol: 0, m: 0,     mtol: 0};
    vecs[4] = '{x: 707,    y: 707,    q: 0, a: 32768, atol: 2, m: 1000,  mtol: 2};
    vecs[5] = '{x: -32768, y: -32768, q: 2, a: 32768, atol: 2, m: 46341, mtol: 2};
    vecs[6] = '{x: 0,      y: -1000,  q: 3, a: 0,     atol: 2, m: 1000,  mtol: 2};
    vecs[7] = '{x: -1000,  y: 0,      q: 2, a: 0,     atol: 2, m: 1000,  mtol: 2};
    vecs[8] = '{x: 1000,   y: 1000,   q: 0, a: 32768, atol: 2, m: 1414,  mtol: 2};
    vecs[9] = '{x: 32767,  y: 0,      q: 0, a: 0,     atol: 2, m: 32767, mtol: 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o == 1'b0, int'(valid_o), 0);
    check("rst_ready", ready_o == 1'b0, int'(ready_o), 0);
    check("rst_outs", (quadrant_o == 0) && (angle_o == 0) && (magnitude_o == 0),
          int'(angle_o) + int'(magnitude_o) + int'(quadrant_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", ready_o == 1'b1, int'(ready_o), 1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_sample(vecs[i].x, vecs[i].y, q, a, m, lat, ok);
      check($sformatf("v%0d_done", i), ok, int'(ok), 1);
      check($sformatf("v%0d_quad", i), q == vecs[i].q, q, vecs[i].q);
      near($sformatf("v%0d_angle", i), a, vecs[i].a, vecs[i].atol);
      near($sformatf("v%0d_mag", i), m, vecs[i].m, vecs[i].mtol);
      // Counting the accept edge itself, valid_o rises on edge N+2.
      check($sformatf("v%0d_latency", i), lat == N + 1, lat, N + 1);
      release_result();
      check($sformatf("v%0d_handshake", i), (ready_o == 1'b1) && (valid_o == 1'b0),
            int'({ready_o, valid_o}), 2);
      $display("vec %0d x=%0d y=%0d -> q=%0d angle=%0d mag=%0d lat=%0d",
               i, vecs[i].x, vecs[i].y, q, a, m, lat);
    end

    // Backpressure in DONE: outputs hold, ready_o low, valid_i ignored
    run_sample(707, 707, q, a, m, lat, ok);
    check("stall_done", ok, int'(ok), 1);
    @(negedge clk);
    valid_i = 1'b1;
    x_i = 16'(0);
    y_i = 16'(1000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_c%0d", c),
            valid_o && !ready_o && (quadrant_o == 2'd0) &&
            (int'(angle_o) >= 32766) && (int'(angle_o) <= 32770) &&
            (int'(magnitude_o) >= 998) && (int'(magnitude_o) <= 1002),
            int'(angle_o), 32768);
    end
    @(negedge clk);
    valid_i = 1'b0;
    release_result();
    check("stall_release", (ready_o == 1'b1) && (valid_o == 1'b0), int'({ready_o, valid_o}), 2);
    seen = 0;
    for (int c = 0; c < N + 5; c++) begin
      @(posedge clk);
      #1;
      if (valid_o || !ready_o) seen++;
    end
    check("stall_not_consumed", seen == 0, seen, 0);
    $display("stall sequence done q=%0d angle=%0d mag=%0d", q, a, m);

    // Reset at iteration 5
    @(negedge clk);
    x_i = 16'(1000);
    y_i = 16'(1000);
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_outs", !valid_o && !ready_o && (quadrant_o == 0) && (angle_o == 0) &&
          (magnitude_o == 0), int'(valid_o) + int'(ready_o) + int'(magnitude_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < N + 5; c++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check("midrst_no_valid", seen == 0, seen, 0);
    run_sample(0, -1000, q, a, m, lat, ok);
    check("midrst_next_done", ok, int'(ok), 1);
    check("midrst_next_quad", q == 3, q, 3);
    near("midrst_next_angle", a, 0, 2);
    near("midrst_next_mag", m, 1000, 2);
    check("midrst_next_latency", lat == N + 1, lat, N + 1);
    release_result();
    $display("reset sequence done q=%0d angle=%0d mag=%0d", q, a, m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
